uart_host: RTL and testbench

- Bus initiator for the UART responder: owns its I_cyc/I_stb/I_we/O_ack/data bus and its data_ready/busy_write status lines.
- Turns a user-side byte stream into paced write cycles, and turns responder data_ready into read cycles.
- Buffers both directions in FIFOs so that CPU-less logic (loaders, debug monitors) gets a plain valid/ready byte interface.

---
 rtl/uart_host.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_uart_host.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_host.sv
// uart_host: bus initiator for the UART responder.
// A user-side byte stream is turned into paced write cycles, and responder
// data_ready is turned into read cycles. Both directions are buffered in
// show-ahead FIFOs so plain valid/ready logic can drive the UART.

module uart_host_fifo #(
    parameter int AW = 4
) (
    input  logic          I_clk,
    input  logic          I_rst_n,
    input  logic          I_push,
    input  logic [7:0]    I_wr_data,
    input  logic          I_pop,
    output logic [7:0]    O_rd_data,
    output logic [AW:0]   O_count,
    output logic          O_full,
    output logic          O_empty
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic        do_push;
    logic        do_pop;

    // One extra pointer bit lets full and empty be told apart by subtraction.
    assign O_count   = wr_ptr_reg - rd_ptr_reg;
    assign O_full    = (O_count == DEPTH_CNT);
    assign O_empty   = (O_count == '0);
    assign do_push   = I_push && !O_full;
    assign do_pop    = I_pop && !O_empty;
    // Show-ahead: the head byte is visible without a read cycle.
    assign O_rd_data = mem[rd_ptr_reg[AW-1:0]];

    // Storage write; contents need no reset because pointers gate visibility.
    always_ff @(posedge I_clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= I_wr_data;
        end
    end

    // Pointer update; simultaneous push and pop keeps the count unchanged.
    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

module uart_host #(
    parameter int FIFO_AW      = 4,
    parameter int GUARD_CYCLES = 418,
    parameter int ACK_TIMEOUT  = 15
) (
    input  logic               I_clk,
    input  logic               I_rst_n,
    input  logic               I_tx_valid,
    input  logic [7:0]         I_tx_data,
    output logic               O_tx_ready,
    output logic               O_rx_valid,
    output logic [7:0]         O_rx_data,
    input  logic               I_rx_ready,
    output logic               O_cyc,
    output logic               O_stb,
    output logic               O_we,
    output logic [7:0]         O_dat,
    input  logic               I_ack,
    input  logic [7:0]         I_dat,
    input  logic               I_data_ready,
    input  logic               I_busy_write,
    output logic [FIFO_AW:0]   O_tx_count,
    output logic [FIFO_AW:0]   O_rx_count,
    output logic               O_bus_err
);

    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam int CW = $clog2(GUARD_CYCLES + 4);
    localparam logic [TW-1:0] TMO_LAST   = TW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] HI_LAST    = CW'(3);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_RD, ST_RD_WAIT, ST_SETTLE, ST_WR, ST_WR_WAIT
    } state_t;

    typedef enum logic [1:0] {
        LK_IDLE, LK_WAIT_HI, LK_WAIT_LO, LK_GUARD
    } lock_t;

    state_t          state_reg, state_next;
    lock_t           lock_reg, lock_next;
    logic [CW-1:0]   lock_cnt_reg, lock_cnt_next;
    logic [TW-1:0]   tmo_reg, tmo_next;
    logic [7:0]      dat_reg, dat_next;
    logic            we_reg, we_next;
    logic [7:0]      rd_dat_reg, rd_dat_next;
    logic            bus_err_reg, bus_err_next;

    logic            tx_pop;
    logic            rx_push;
    logic            wr_abort;
    logic            tx_lock;
    logic [7:0]      tx_head;
    logic            tx_full, tx_empty;
    logic            rx_full, rx_empty;

    uart_host_fifo #(.AW(FIFO_AW)) u_tx_fifo (
        .I_clk     (I_clk),
        .I_rst_n   (I_rst_n),
        .I_push    (I_tx_valid),
        .I_wr_data (I_tx_data),
        .I_pop     (tx_pop),
        .O_rd_data (tx_head),
        .O_count   (O_tx_count),
        .O_full    (tx_full),
        .O_empty   (tx_empty)
    );

    uart_host_fifo #(.AW(FIFO_AW)) u_rx_fifo (
        .I_clk     (I_clk),
        .I_rst_n   (I_rst_n),
        .I_push    (rx_push),
        .I_wr_data (rd_dat_reg),
        .I_pop     (I_rx_ready),
        .O_rd_data (O_rx_data),
        .O_count   (O_rx_count),
        .O_full    (rx_full),
        .O_empty   (rx_empty)
    );

    assign O_tx_ready = !tx_full;
    assign O_rx_valid = !rx_empty;
    assign O_stb      = (state_reg == ST_RD) || (state_reg == ST_WR);
    assign O_cyc      = O_stb;
    assign O_we       = we_reg;
    assign O_dat      = dat_reg;
    assign O_bus_err  = bus_err_reg;
    assign tx_lock    = (lock_reg != LK_IDLE);

    // Bus sequencer state and held cycle attributes.
    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            state_reg   <= ST_IDLE;
            tmo_reg     <= '0;
            dat_reg     <= '0;
            we_reg      <= 1'b0;
            rd_dat_reg  <= '0;
            bus_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            tmo_reg     <= tmo_next;
            dat_reg     <= dat_next;
            we_reg      <= we_next;
            rd_dat_reg  <= rd_dat_next;
            bus_err_reg <= bus_err_next;
        end
    end

    // Bus sequencer next state: reads win over writes, one cycle at a time.
    always_comb begin
        state_next   = state_reg;
        tmo_next     = tmo_reg;
        dat_next     = dat_reg;
        we_next      = we_reg;
        rd_dat_next  = rd_dat_reg;
        bus_err_next = bus_err_reg;
        tx_pop       = 1'b0;
        rx_push      = 1'b0;
        wr_abort     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (I_data_ready && !rx_full) begin
                    state_next = ST_RD;
                    we_next    = 1'b0;
                end else if (!tx_empty && !tx_lock && !I_busy_write) begin
                    // Latch the head now so O_dat is already valid while strobing.
                    state_next = ST_WR;
                    we_next    = 1'b1;
                    dat_next   = tx_head;
                    tx_pop     = 1'b1;
                end
            end
            ST_RD: begin
                tmo_next   = '0;
                state_next = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (I_ack) begin
                    rd_dat_next = I_dat;
                    state_next  = ST_SETTLE;
                end else if (tmo_reg == TMO_LAST) begin
                    bus_err_next = 1'b1;
                    state_next   = ST_IDLE;
                end else begin
                    tmo_next = tmo_reg + 1'b1;
                end
            end
            ST_SETTLE: begin
                // The captured byte lands here while data_ready clears.
                rx_push    = 1'b1;
                state_next = ST_IDLE;
            end
            ST_WR: begin
                tmo_next   = '0;
                state_next = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (I_ack) begin
                    state_next = ST_IDLE;
                end else if (tmo_reg == TMO_LAST) begin
                    bus_err_next = 1'b1;
                    wr_abort     = 1'b1;
                    state_next   = ST_IDLE;
                end else begin
                    tmo_next = tmo_reg + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // TX pacing state: holds off further writes until the responder is free.
    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            lock_reg     <= LK_IDLE;
            lock_cnt_reg <= '0;
        end else begin
            lock_reg     <= lock_next;
            lock_cnt_reg <= lock_cnt_next;
        end
    end

    // TX pacing next state: busy rise, busy fall, then a guard gap.
    always_comb begin
        lock_next     = lock_reg;
        lock_cnt_next = lock_cnt_reg;
        if (wr_abort) begin
            lock_next     = LK_IDLE;
            lock_cnt_next = '0;
        end else begin
            case (lock_reg)
                LK_IDLE: begin
                    if (state_reg == ST_WR) begin
                        lock_next     = LK_WAIT_HI;
                        lock_cnt_next = '0;
                    end
                end
                LK_WAIT_HI: begin
                    if (I_busy_write) begin
                        lock_next = LK_WAIT_LO;
                    end else if (lock_cnt_reg == HI_LAST) begin
                        // Busy never showed; fall back to the guard alone.
                        lock_next     = LK_GUARD;
                        lock_cnt_next = '0;
                    end else begin
                        lock_cnt_next = lock_cnt_reg + 1'b1;
                    end
                end
                LK_WAIT_LO: begin
                    if (!I_busy_write) begin
                        lock_next     = LK_GUARD;
                        lock_cnt_next = '0;
                    end
                end
                LK_GUARD: begin
                    if (lock_cnt_reg == GUARD_LAST) begin
                        lock_next     = LK_IDLE;
                        lock_cnt_next = '0;
                    end else begin
                        lock_cnt_next = lock_cnt_reg + 1'b1;
                    end
                end
                default: lock_next = LK_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_host.sv
// tb_uart_host: directed bench for uart_host with a behavioural responder
// and queue scoreboards for written and received bytes.

module tb_uart_host;

    localparam int AW       = 4;
    localparam int GUARD    = 418;
    localparam int TMO      = 15;
    localparam int BUSY_LEN = 20;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_ready;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          cyc, stb, we;
    logic [7:0]    dat;
    logic          ack = 1'b0;
    logic [7:0]    rsp_byte = 8'h00;
    logic          data_ready = 1'b0;
    logic          busy = 1'b0;
    logic [AW:0]   tx_count, rx_count;
    logic          bus_err;

    int tests = 0;
    int fails = 0;
    int cyc_cnt = 0;
    int busy_cnt = 0;
    int fall_cyc = -1000000;
    int wr_strobes = 0;
    int rd_strobes = 0;
    int last_wr_cyc = -100000;
    int last_rd_cyc = -100000;
    logic ack_en = 1'b1;
    byte unsigned exp_wr[$];
    byte unsigned exp_rx[$];
    byte unsigned rsp_q[$];

    always #5 clk = ~clk;

    uart_host #(.FIFO_AW(AW), .GUARD_CYCLES(GUARD), .ACK_TIMEOUT(TMO)) dut (
        .I_clk        (clk),
        .I_rst_n      (rst_n),
        .I_tx_valid   (tx_valid),
        .I_tx_data    (tx_data),
        .O_tx_ready   (tx_ready),
        .O_rx_valid   (rx_valid),
        .O_rx_data    (rx_data),
        .I_rx_ready   (rx_ready),
        .O_cyc        (cyc),
        .O_stb        (stb),
        .O_we         (we),
        .O_dat        (dat),
        .I_ack        (ack),
        .I_dat        (rsp_byte),
        .I_data_ready (data_ready),
        .I_busy_write (busy),
        .O_tx_count   (tx_count),
        .O_rx_count   (rx_count),
        .O_bus_err    (bus_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Responder model: ack one cycle after strobe, holds a byte until read,
    // and raises busy for BUSY_LEN cycles after each acknowledged write.
    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (rst_n !== 1'b1) begin
            ack        <= 1'b0;
            data_ready <= 1'b0;
            busy       <= 1'b0;
            busy_cnt   <= 0;
        end else begin
            ack <= stb && ack_en;
            if (stb && ack_en && !we) begin
                data_ready <= 1'b0;
            end else if (!data_ready && rsp_q.size() > 0) begin
                rsp_byte   <= rsp_q.pop_front();
                data_ready <= 1'b1;
            end
            if (stb && ack_en && we) begin
                busy     <= 1'b1;
                busy_cnt <= BUSY_LEN;
            end else if (busy_cnt > 0) begin
                busy_cnt <= busy_cnt - 1;
                if (busy_cnt == 1) begin
                    busy     <= 1'b0;
                    fall_cyc <= cyc_cnt + 1;
                end
            end
        end
    end

    // Strobe monitor: scoreboard write data and the guard gap after busy falls.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && stb === 1'b1) begin
            check("cyc_eq_stb", cyc, stb);
            if (we) begin
                check("wr_pending", exp_wr.size() > 0, 1);
                if (exp_wr.size() > 0) check("wr_data", dat, exp_wr.pop_front());
                if (fall_cyc > last_wr_cyc) check("guard_gap", (cyc_cnt - fall_cyc) >= GUARD, 1);
                last_wr_cyc = cyc_cnt;
                wr_strobes++;
            end else begin
                last_rd_cyc = cyc_cnt;
                rd_strobes++;
            end
        end
    end

    task automatic wait_wr(input int prev, input int bound, input string tag);
        int n = 0;
        while (wr_strobes == prev && n < bound) begin step(); n++; end
        check(tag, wr_strobes != prev, 1);
    endtask

    task automatic send(input logic [7:0] b);
        exp_wr.push_back(b);
        tx_valid = 1'b1;
        tx_data  = b;
        step();
        tx_valid = 1'b0;
    endtask

    task automatic pop_rx(input string tag);
        int n = 0;
        while (rx_valid !== 1'b1 && n < 50) begin step(); n++; end
        check({tag, "_valid"}, rx_valid, 1);
        check({tag, "_pending"}, exp_rx.size() > 0, 1);
        if (exp_rx.size() > 0) check({tag, "_data"}, rx_data, exp_rx.pop_front());
        rx_ready = 1'b1;
        step();
        rx_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0, r0, r1, n, s_obs;
        rst_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Reset while a write strobe is high.
        send(8'h11);
        n = 0;
        while (stb !== 1'b1 && n < 10) begin step(); n++; end
        check("pre_reset_stb", stb, 1);
        rst_n = 1'b0;
        step();
        check("rst_stb_drop", stb, 0);
        step(); step();
        check("rst_cyc", cyc, 0);
        check("rst_we", we, 0);
        check("rst_dat", dat, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_count", tx_count, 0);
        check("rst_rx_count", rx_count, 0);
        check("rst_bus_err", bus_err, 0);
        rst_n = 1'b1;
        step();

        // Two paced writes.
        w0 = wr_strobes;
        send(8'h55);
        send(8'hA3);
        wait_wr(w0, 20, "wr1_seen");
        wait_wr(w0 + 1, 1500, "wr2_seen");
        check("wr_count", wr_strobes - w0, 2);
        check("wr_tx_empty", tx_count, 0);
        repeat (500) step();

        // Single read.
        r0 = rd_strobes;
        rsp_q.push_back(8'h3C); exp_rx.push_back(8'h3C);
        n = 0;
        while (rx_valid !== 1'b1 && n < 20) begin step(); n++; end
        check("rd_valid_rise", rx_valid, 1);
        repeat (5) step();
        check("rd_one_strobe", rd_strobes - r0, 1);
        pop_rx("rd_3c");
        check("rd_count_zero", rx_count, 0);

        // Fill RX FIFO with data_ready still pending.
        r0 = rd_strobes;
        for (int i = 0; i < 17; i++) begin
            rsp_q.push_back(8'(8'h80 + i));
            exp_rx.push_back(8'(8'h80 + i));
        end
        n = 0;
        while (rx_count != 16 && n < 200) begin step(); n++; end
        check("fill_count", rx_count, 16);
        repeat (20) step();
        check("fill_reads", rd_strobes - r0, 16);
        check("fill_dr_held", data_ready, 1);
        check("fill_tx_ready", tx_ready, 1);
        r1 = rd_strobes;
        pop_rx("fill_first");
        n = 0;
        while (rd_strobes == r1 && n < 5) begin step(); n++; end
        check("refill_latency", n <= 2, 1);
        for (int i = 1; i < 17; i++) pop_rx("fill");
        check("fill_drained", rx_count, 0);

        // Read and write pending in the same cycle.
        repeat (10) step();
        w0 = wr_strobes; r0 = rd_strobes;
        rsp_q.push_back(8'h99); exp_rx.push_back(8'h99);
        send(8'hC4);
        wait_wr(w0, 30, "prio_wr_seen");
        check("prio_one_read", rd_strobes - r0, 1);
        check("prio_read_first", last_rd_cyc < last_wr_cyc, 1);
        check("prio_after_settle", (last_wr_cyc - last_rd_cyc) >= 3, 1);
        pop_rx("prio");
        repeat (500) step();

        // Ack timeout.
        ack_en = 1'b0;
        w0 = wr_strobes;
        send(8'h77);
        wait_wr(w0, 10, "tmo_wr_seen");
        s_obs = cyc_cnt;
        repeat (TMO - 1) step();
        check("tmo_err_not_early", bus_err, 0);
        repeat (2) step();
        check("tmo_err_set", bus_err, 1);
        check("tmo_stb_low", stb, 0);
        check("tmo_elapsed", cyc_cnt - s_obs, TMO + 1);
        ack_en = 1'b1;
        step();

        // Traffic after the error.
        w0 = wr_strobes;
        send(8'h81);
        wait_wr(w0, 20, "post_err_wr");
        rsp_q.push_back(8'h5A); exp_rx.push_back(8'h5A);
        pop_rx("post_err_rd");
        check("err_sticky", bus_err, 1);
        check("wr_all_seen", exp_wr.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
